rfid_uid_matcher: RTL and testbench
===================================

RFID_UID_MATCHER -- requirements
Module: rfid_uid_matcher

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4, meaning tag table depth (power of 2, 2..16).
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 50_000_000, meaning repeat-suppression window in clk cycles.
REQ-003 SHALL have parameter IDW, default $clog2(N_ENTRIES), meaning match index width.
REQ-004 clk  input  1  system clock; the block uses this single clock and is clocked on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 uid  input  32  UID from the RC522 controller; sampled only when uid_valid=1.
REQ-007 uid_valid  input  1  one-cycle pulse from the controller (its done output).
REQ-008 enroll  input  1  level; when sampled high together with uid_valid, the read is an enrolment.
REQ-009 clear  input  1  one-cycle request to empty the table.
REQ-010 result_valid  output  1  one-cycle pulse; match, unknown and match_id are meaningful.
REQ-011 match  output  1  UID is found in (or was just added to) the table; valid with result_valid.
REQ-012 unknown  output  1  UID was not found, or enrolment failed because the table is full; valid with result_valid.
REQ-013 match_id  output  IDW  table index of the hit; holds until the next result.
REQ-014 entry_count  output  IDW+1  number of enrolled entries.
REQ-015 table_full  output  1  entry_count==N_ENTRIES.
REQ-016 busy  output  1  FSM not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, COMPARE, ENROLL, REPORT.
REQ-018 IDLE: on uid_valid with a valid UID, the block SHALL latch uid and enroll, zero the index and go to COMPARE.
REQ-019 uid values 0x00000000 and 0xFFFFFFFF SHALL be ignored: no state change, no result.
REQ-020 If uid equals the last reported UID and the cooldown counter is nonzero, the read SHALL be ignored.
REQ-021 COMPARE: one entry per cycle, index 0 upward; on a hit, go to REPORT with match=1 and match_id=index.
REQ-022 COMPARE exhausted (index==entry_count, including entry_count=0), not enrolling: go to REPORT with unknown=1.
REQ-023 COMPARE exhausted, enrolling, not full: go to ENROLL.
REQ-024 COMPARE exhausted, enrolling, full: go to REPORT with unknown=1; the table is unchanged.
REQ-025 An enrolment of an already-present UID SHALL report match with the existing index and add no duplicate.
REQ-026 ENROLL: write the UID at index entry_count, increment entry_count, go to REPORT with match=1 and match_id=old entry_count.
REQ-027 REPORT: assert result_valid for exactly one cycle, record last UID, reload cooldown to COOLDOWN_CYCLES-1, return to IDLE.
REQ-028 Latency, lookup: uid_valid at cycle T with a hit at entry k SHALL give result_valid at T+2+k.
REQ-029 Latency, miss: with entry_count=n, result_valid SHALL occur at T+2+n; an enrolment adds one cycle.
REQ-030 uid_valid while busy SHALL be dropped, with no effect.
REQ-031 The cooldown counter SHALL decrement to 0 and saturate there.
REQ-032 A different UID SHALL be processed normally regardless of cooldown.
REQ-033 clear SHALL take effect in any state:
- entry_count=0, go to IDLE, cooldown=0;
- any in-flight operation is aborted with no result_valid.
REQ-034 clear and uid_valid in the same cycle: clear SHALL win and the UID is dropped.
REQ-035 match and unknown SHALL be 0 whenever result_valid=0; they are mutually exclusive.

Reset
REQ-036 rst SHALL set:
- state=IDLE, entry_count=0, cooldown=0, last UID=0;
- match_id=0, and all 1-bit outputs=0.
REQ-037 Table contents need not be reset; entries at index >= entry_count SHALL never produce a hit.
REQ-038 rst mid-operation SHALL abort the operation without emitting result_valid.

Structure
REQ-039 The state encoding and the invalid-UID constants (32'h0, 32'hFFFFFFFF) SHALL live in shared package rfid_pkg.
REQ-040 The table storage SHALL be a sub-module uid_table: N_ENTRIES x 32-bit, one synchronous write port, one combinational indexed read port.

Verification (N_ENTRIES=4, COOLDOWN_CYCLES=16)
REQ-041 Empty table; enroll=1 with uid 0xABCDEF12 at T -> result_valid at T+3, match=1, match_id=0, entry_count=1.
REQ-042 Then, after cooldown expires, present 0xABCDEF12 with enroll=0 -> match=1, match_id=0 at T+2; with entry_count=1, present 0x12345678 -> unknown=1 at T+3.
REQ-043 Present 0xABCDEF12 twice, 5 cycles apart -> exactly one result; present it again 20 cycles after the first result -> second result.
REQ-044 Enroll 4 distinct UIDs (table_full=1), then enroll 0xCAFEBABE -> unknown=1, entry_count stays 4; re-enroll entry 2 -> match_id=2, no duplicate.
REQ-045 clear pulsed during COMPARE, and rst pulsed during COMPARE -> no result_valid, entry_count=0, busy=0 next cycle.
REQ-046 uid 0x00000000 or 0xFFFFFFFF, and uid_valid while busy -> ignored, no result, table unchanged.

Source files
------------

// File: rtl/rfid_pkg.sv
// Shared definitions for the RFID UID matcher.
//   state_e          : matcher FSM state encoding
//   UID_INVALID_ZERO : reader "no tag" pattern, never processed
//   UID_INVALID_ONES : reader bus-idle pattern, never processed
//   uid_is_valid()   : true when a UID is not one of the invalid patterns
package rfid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_ENROLL,
    ST_REPORT
  } state_e;

  localparam logic [31:0] UID_INVALID_ZERO = 32'h0000_0000;
  localparam logic [31:0] UID_INVALID_ONES = 32'hFFFF_FFFF;

  function automatic logic uid_is_valid(input logic [31:0] u);
    return (u != UID_INVALID_ZERO) && (u != UID_INVALID_ONES);
  endfunction

endpackage

// File: rtl/uid_table.sv
// Tag table storage: N_ENTRIES x 32-bit, one synchronous write port and
// one combinational indexed read port. Contents are not reset.
//   clk     : system clock (rising edge)
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : UID to store
//   raddr_i : read index
//   rdata_o : UID stored at raddr_i
module uid_table #(
  parameter int N_ENTRIES = 4,
  parameter int IDW       = $clog2(N_ENTRIES)
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [IDW-1:0] waddr_i,
  input  logic [31:0]    wdata_i,
  input  logic [IDW-1:0] raddr_i,
  output logic [31:0]    rdata_o
);

  logic [31:0] mem_q [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rfid_uid_matcher.sv
// RFID UID matcher: looks up reader UIDs in a small tag table, optionally
// enrolling new ones, and suppresses repeat reports of the same UID within
// a cooldown window.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   uid          : UID from the reader, sampled on uid_valid
//   uid_valid    : one-cycle read-done pulse
//   enroll       : level; read is an enrolment when high with uid_valid
//   clear        : one-cycle request to empty the table
//   result_valid : one-cycle result pulse
//   match        : UID found in / added to the table
//   unknown      : UID not found, or enrolment refused (table full)
//   match_id     : index of the last hit, held between results
//   entry_count  : number of enrolled entries
//   table_full   : entry_count == N_ENTRIES
//   busy         : FSM not idle
module rfid_uid_matcher
  import rfid_pkg::*;
#(
  parameter int N_ENTRIES       = 4,
  parameter int COOLDOWN_CYCLES = 50_000_000,
  parameter int IDW             = $clog2(N_ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    uid,
  input  logic           uid_valid,
  input  logic           enroll,
  input  logic           clear,
  output logic           result_valid,
  output logic           match,
  output logic           unknown,
  output logic [IDW-1:0] match_id,
  output logic [IDW:0]   entry_count,
  output logic           table_full,
  output logic           busy
);

  localparam int CDW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CDW-1:0] CD_RELOAD = CDW'(COOLDOWN_CYCLES - 1);
  localparam logic [IDW:0]   FULL_CNT  = (IDW+1)'(N_ENTRIES);

  state_e         state_q, state_d;
  logic [31:0]    uid_q, uid_d;
  logic [31:0]    last_q, last_d;
  logic           enroll_q, enroll_d;
  logic [IDW:0]   idx_q, idx_d;
  logic [IDW:0]   count_q, count_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [IDW-1:0] match_id_q, match_id_d;
  logic           res_match_q, res_match_d;
  logic           res_unknown_q, res_unknown_d;

  logic           tbl_we;
  logic [31:0]    tbl_rdata;
  logic           full;

  assign full = (count_q == FULL_CNT);

  uid_table #(
    .N_ENTRIES (N_ENTRIES),
    .IDW       (IDW)
  ) u_table (
    .clk     (clk),
    .we_i    (tbl_we),
    .waddr_i (count_q[IDW-1:0]),
    .wdata_i (uid_q),
    .raddr_i (idx_q[IDW-1:0]),
    .rdata_o (tbl_rdata)
  );

  always_comb begin
    state_d       = state_q;
    uid_d         = uid_q;
    last_d        = last_q;
    enroll_d      = enroll_q;
    idx_d         = idx_q;
    count_d       = count_q;
    cd_d          = (cd_q != '0) ? cd_q - 1'b1 : cd_q;
    match_id_d    = match_id_q;
    res_match_d   = res_match_q;
    res_unknown_d = res_unknown_q;
    tbl_we        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (uid_valid && uid_is_valid(uid) &&
            !((uid == last_q) && (cd_q != '0))) begin
          uid_d    = uid;
          enroll_d = enroll;
          idx_d    = '0;
          state_d  = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        // Exhaustion is tested before the read so stale entries at
        // index >= entry_count can never hit.
        if (idx_q == count_q) begin
          if (enroll_q && !full) begin
            state_d = ST_ENROLL;
          end else begin
            res_match_d   = 1'b0;
            res_unknown_d = 1'b1;
            state_d       = ST_REPORT;
          end
        end else if (tbl_rdata == uid_q) begin
          res_match_d   = 1'b1;
          res_unknown_d = 1'b0;
          match_id_d    = idx_q[IDW-1:0];
          state_d       = ST_REPORT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ENROLL: begin
        tbl_we        = 1'b1;
        count_d       = count_q + 1'b1;
        match_id_d    = count_q[IDW-1:0];
        res_match_d   = 1'b1;
        res_unknown_d = 1'b0;
        state_d       = ST_REPORT;
      end
      ST_REPORT: begin
        last_d  = uid_q;
        cd_d    = CD_RELOAD;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      cd_d    = '0;
      last_d  = last_q;
      tbl_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      uid_q         <= '0;
      last_q        <= '0;
      enroll_q      <= 1'b0;
      idx_q         <= '0;
      count_q       <= '0;
      cd_q          <= '0;
      match_id_q    <= '0;
      res_match_q   <= 1'b0;
      res_unknown_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      uid_q         <= uid_d;
      last_q        <= last_d;
      enroll_q      <= enroll_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      cd_q          <= cd_d;
      match_id_q    <= match_id_d;
      res_match_q   <= res_match_d;
      res_unknown_q <= res_unknown_d;
    end
  end

  // A clear arriving in the REPORT cycle aborts the result as well.
  assign result_valid = (state_q == ST_REPORT) && !clear;
  assign match        = result_valid && res_match_q;
  assign unknown      = result_valid && res_unknown_q;
  assign match_id     = match_id_q;
  assign entry_count  = count_q;
  assign table_full   = full;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rfid_uid_matcher.sv
module tb_rfid_uid_matcher;

  localparam int NE  = 4;
  localparam int CD  = 16;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [31:0]    uid;
  logic           uid_valid;
  logic           enroll;
  logic           clear;
  logic           result_valid;
  logic           match;
  logic           unknown;
  logic [IDW-1:0] match_id;
  logic [IDW:0]   entry_count;
  logic           table_full;
  logic           busy;

  rfid_uid_matcher #(
    .N_ENTRIES       (NE),
    .COOLDOWN_CYCLES (CD),
    .IDW             (IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uid          (uid),
    .uid_valid    (uid_valid),
    .enroll       (enroll),
    .clear        (clear),
    .result_valid (result_valid),
    .match        (match),
    .unknown      (unknown),
    .match_id     (match_id),
    .entry_count  (entry_count),
    .table_full   (table_full),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic em;
    logic eu;
    bit   chk_id;
    int   eid;
    int   ecnt;
    int   ecyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got result at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("match", int'(match), int'(e.em));
          check("unknown", int'(unknown), int'(e.eu));
          if (e.chk_id) check("match_id", int'(match_id), e.eid);
          check("entry_count", int'(entry_count), e.ecnt);
          check("latency_cycle", cyc, e.ecyc);
        end
      end else if (match || unknown) begin
        total++;
        bad++;
        $display("FAIL flags_without_valid: got match=%0b unknown=%0b expected 0", match, unknown);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read; push the expected response if one should follow.
  task automatic send(input logic [31:0] u, input logic en, input bit exp_res,
                      input logic em, input logic eu, input int eid,
                      input int ecnt, input int lat);
    exp_t e;
    if (exp_res) begin
      e.em = em; e.eu = eu; e.chk_id = em; e.eid = eid;
      e.ecnt = ecnt; e.ecyc = cyc + lat;
      sb.push_back(e);
    end
    uid = u; uid_valid = 1'b1; enroll = en;
    tick();
    uid_valid = 1'b0; enroll = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 40 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; uid = '0; uid_valid = 1'b0; enroll = 1'b0; clear = 1'b0;
    repeat (3) tick();
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_match", int'(match), 0);
    check("rst_unknown", int'(unknown), 0);
    check("rst_match_id", int'(match_id), 0);
    check("rst_entry_count", int'(entry_count), 0);
    check("rst_table_full", int'(table_full), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // Enrol into empty table: compare(exhausted) + enroll + report.
    send(32'hABCD_EF12, 1'b1, 1, 1, 0, 0, 1, 3);
    wait_idle();
    repeat (20) tick();
    // Lookup hit at entry 0; then a miss against one entry.
    send(32'hABCD_EF12, 1'b0, 1, 1, 0, 0, 1, 2);
    wait_idle();
    send(32'h1234_5678, 1'b0, 1, 0, 1, 0, 1, 3);
    wait_idle();
    repeat (20) tick();

    // Repeat suppression within cooldown, accepted after it expires.
    send(32'hABCD_EF12, 1'b0, 1, 1, 0, 0, 1, 2);
    wait_idle();
    repeat (2) tick();
    send(32'hABCD_EF12, 1'b0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    check("suppressed_busy", int'(busy), 0);
    repeat (18) tick();
    send(32'hABCD_EF12, 1'b0, 1, 1, 0, 0, 1, 2);
    wait_idle();

    // Fill the table.
    send(32'h1111_1111, 1'b1, 1, 1, 0, 1, 2, 4);
    wait_idle();
    send(32'h2222_2222, 1'b1, 1, 1, 0, 2, 3, 5);
    wait_idle();
    send(32'h3333_3333, 1'b1, 1, 1, 0, 3, 4, 6);
    wait_idle();
    check("table_full", int'(table_full), 1);
    send(32'hCAFE_BABE, 1'b1, 1, 0, 1, 0, 4, 6);
    wait_idle();
    send(32'h2222_2222, 1'b1, 1, 1, 0, 2, 4, 4);
    wait_idle();
    check("no_duplicate_count", int'(entry_count), 4);

    // Invalid UIDs ignored.
    send(32'h0000_0000, 1'b1, 0, 0, 0, 0, 0, 0);
    check("zero_uid_busy", int'(busy), 0);
    send(32'hFFFF_FFFF, 1'b1, 0, 0, 0, 0, 0, 0);
    check("ones_uid_busy", int'(busy), 0);
    // uid_valid while busy is dropped.
    send(32'h1111_1111, 1'b0, 1, 1, 0, 1, 4, 3);
    send(32'h3333_3333, 1'b1, 0, 0, 0, 0, 0, 0);
    wait_idle();
    repeat (3) tick();
    check("busy_drop_count", int'(entry_count), 4);

    // clear during COMPARE aborts.
    send(32'h3333_3333, 1'b0, 0, 0, 0, 0, 0, 0);
    check("in_compare_busy", int'(busy), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy", int'(busy), 0);
    check("clear_count", int'(entry_count), 0);
    check("clear_full", int'(table_full), 0);
    repeat (6) tick();

    send(32'h4444_4444, 1'b1, 1, 1, 0, 0, 1, 3);
    wait_idle();
    send(32'h5555_5555, 1'b1, 1, 1, 0, 1, 2, 4);
    wait_idle();
    send(32'h4444_4444, 1'b0, 1, 1, 0, 0, 2, 2);
    wait_idle();

    // rst during COMPARE aborts; stale table entries must not hit.
    send(32'h5555_5555, 1'b0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_count", int'(entry_count), 0);
    check("rst_mid_match_id", int'(match_id), 0);
    send(32'h4444_4444, 1'b0, 1, 0, 1, 0, 0, 2);
    wait_idle();

    // clear and uid_valid together: clear wins.
    uid = 32'h5555_5555; uid_valid = 1'b1; enroll = 1'b1; clear = 1'b1;
    tick();
    uid_valid = 1'b0; enroll = 1'b0; clear = 1'b0;
    check("clear_wins_busy", int'(busy), 0);
    repeat (6) tick();
    check("clear_wins_count", int'(entry_count), 0);

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
